cmd_frame_parser: RTL and testbench

- Byte-stream command deframer that sits directly upstream of the command register decoder.
- Consumes bytes from the UART receiver and assembles fixed 7-byte frames.
- Validates each frame's checksum and emits a single-cycle `cmdvalid` with an 8-bit address and a 32-bit data word, driving the decoder's `cmdvalid` / `cmd_addr` / `cmd_data` inputs.
- Flags malformed and stalled frames and counts errors for debug readback.

---
 rtl/cmd_frame_parser.sv | 101 ++++++++++
 tb/tb_cmd_frame_parser.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// Deframes HEADER,ADDR,D3..D0,CSUM byte frames from the UART receiver into
// single-cycle command strobes, with checksum/timeout error reporting.
module cmd_frame_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         ERRCNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                cmdvalid,
  output logic [7:0]          cmd_addr,
  output logic [31:0]         cmd_data,
  output logic                csum_err,
  output logic                timeout_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  acc;
  logic [7:0]  shadow_addr;
  logic [31:0] shadow_data;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      shadow_addr <= '0;
      shadow_data <= '0;
      tcnt        <= '0;
      cmdvalid    <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      err_cnt     <= '0;
      busy        <= 1'b0;
    end else begin
      cmdvalid    <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (rx_valid && rx_data == HEADER) begin
          state <= ADDR;
          acc   <= '0;
          busy  <= 1'b1;
        end
      end else if (rx_valid) begin
        // Any byte inside a frame restarts the inter-byte timer, even on the expiry cycle.
        tcnt <= '0;
        unique case (state)
          ADDR: begin
            shadow_addr <= rx_data;
            acc         <= rx_data;
            idx         <= '0;
            state       <= DATA;
          end
          DATA: begin
            shadow_data <= {shadow_data[23:0], rx_data};
            acc         <= acc + rx_data;
            if (idx == 2'd3) state <= CSUM;
            else             idx   <= idx + 2'd1;
          end
          CSUM: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_data == acc) begin
              cmdvalid <= 1'b1;
              cmd_addr <= shadow_addr;
              cmd_data <= shadow_data;
            end else begin
              csum_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TLAST) begin
        state       <= IDLE;
        busy        <= 1'b0;
        tcnt        <= '0;
        timeout_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Cycle-by-cycle comparison of cmd_frame_parser against a frame-level byte-queue model.
module tb_cmd_frame_parser;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int TO = 20;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          cmdvalid, csum_err, timeout_err, busy;
  logic [7:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic [EW-1:0] err_cnt;

  always #5 clk = ~clk;

  cmd_frame_parser #(.HEADER(HDR), .TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmdvalid(cmdvalid), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .csum_err(csum_err), .timeout_err(timeout_err), .err_cnt(err_cnt), .busy(busy)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference model: bytes of the frame being collected, plus idle cycles since the last byte.
  logic [7:0]    q[$];
  int            idle;
  logic          e_cv, e_ce, e_to, e_busy;
  logic [7:0]    e_addr;
  logic [31:0]   e_data;
  logic [EW-1:0] e_err;

  task automatic model_reset();
    q.delete(); idle = 0;
    e_cv = 0; e_ce = 0; e_to = 0; e_busy = 0;
    e_addr = 0; e_data = 0; e_err = 0;
  endtask

  task automatic bump_err();
    if (e_err != '1) e_err = e_err + 1'b1;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int s;
    e_cv = 0; e_ce = 0; e_to = 0;
    if (q.size() == 0) begin
      if (v && d == HDR) begin q.push_back(d); idle = 0; end
    end else if (v) begin
      q.push_back(d); idle = 0;
      if (q.size() == 7) begin
        s = q[1] + q[2] + q[3] + q[4] + q[5];
        if (s[7:0] == q[6]) begin
          e_cv = 1; e_addr = q[1]; e_data = {q[2], q[3], q[4], q[5]};
        end else begin
          e_ce = 1; bump_err();
        end
        q.delete();
      end
    end else if (idle == TO - 1) begin
      e_to = 1; bump_err(); q.delete();
    end else begin
      idle++;
    end
    e_busy = (q.size() != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cmdvalid", 32'(cmdvalid), 32'(e_cv));
    chk("csum_err", 32'(csum_err), 32'(e_ce));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err_cnt", 32'(err_cnt), 32'(e_err));
    chk("cmd_addr", 32'(cmd_addr), 32'(e_addr));
    chk("cmd_data", cmd_data, e_data);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v; rx_data = d;
    model_step(v, d);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [55:0] f, input int gap);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, f[55 - 8*i -: 8]);
      if (i < 6) idle_n(gap);
    end
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] dw;
    logic [7:0]  cs;
    int          g, n;

    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    reset = 1'b0;
    cyc(1'b0, 8'h00);

    // Basic frame, zero gap
    send_frame(56'hA5_01_00_00_00_0F_10, 0);
    chk("tp1_pulse", 32'(cmdvalid), 32'd1);
    chk("tp1_addr", 32'(cmd_addr), 32'h01);
    chk("tp1_data", cmd_data, 32'h0000000F);
    idle_n(2);

    // Gapped frame followed immediately by a zero-gap frame
    send_frame(56'hA5_06_12_34_56_78_1A, 3);
    chk("tp2_data", cmd_data, 32'h12345678);
    send_frame(56'hA5_00_00_00_00_00_00, 0);
    chk("tp2b_addr", 32'(cmd_addr), 32'h00);
    idle_n(1);

    // Checksum error
    send_frame(56'hA5_02_00_00_01_00_FF, 1);
    chk("tp3_csum_err", 32'(csum_err), 32'd1);
    chk("tp3_err_cnt", 32'(err_cnt), 32'd1);
    idle_n(1);

    // Garbage then stalled frame
    cyc(1'b1, 8'h11); cyc(1'b1, 8'h22);
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h03); cyc(1'b1, 8'h00);
    idle_n(TO);
    chk("tp4_timeout", 32'(timeout_err), 32'd1);
    chk("tp4_busy", 32'(busy), 32'd0);
    chk("tp4_err_cnt", 32'(err_cnt), 32'd2);
    send_frame(56'hA5_03_00_00_00_05_08, 0);
    chk("tp4_data", cmd_data, 32'h00000005);

    // Byte arriving on the exact expiry cycle, header value as data
    send_frame(56'hA5_01_A5_A5_A5_A5_95, TO - 1);
    chk("tp5_data", cmd_data, 32'hA5A5A5A5);
    idle_n(1);

    // Random frames with random gaps, corruption and stalls
    for (int k = 0; k < 40; k++) begin
      a  = 8'($urandom);
      dw = $urandom;
      cs = a + dw[31:24] + dw[23:16] + dw[15:8] + dw[7:0];
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) cyc(1'b1, 8'($urandom_range(0, 8'hA4)));
      g = $urandom_range(0, 7);
      if (g == 6) g = TO - 1;
      else if (g == 7) g = TO;
      else g = g % 3;
      send_frame({HDR, a, dw, cs}, g);
      idle_n($urandom_range(0, 2));
    end
    idle_n(TO + 1);

    // Reset during D2: remaining bytes must be ignored
    cyc(1'b1, 8'hA5); cyc(1'b1, 8'h07); cyc(1'b1, 8'h11); cyc(1'b1, 8'h22);
    pulse_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    cyc(1'b1, 8'h33); cyc(1'b1, 8'h44); cyc(1'b1, 8'hB1);
    chk("rst_no_pulse", 32'(cmdvalid), 32'd0);
    send_frame(56'hA5_07_11_22_33_44_B1, 0);
    chk("rst_next_data", cmd_data, 32'h11223344);
    idle_n(1);

    // Error counter saturation
    for (int k = 0; k < (1 << EW) + 2; k++) send_frame(56'hA5_02_00_00_01_00_FF, 0);
    chk("sat_err_cnt", 32'(err_cnt), 32'hF);
    chk("sat_addr", 32'(cmd_addr), 32'h07);
    idle_n(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
